dmem_dma: RTL
=============

# dmem_dma

Block-transfer engine that sits directly upstream of the 256×8 data memory and owns its single address/write port. When idle it passes the core's memory requests straight through. When started, it takes over the port and either copies a block of bytes from one dmem region to another or fills a region with a constant. The memory's combinational read and registered write define the 2-cycle-per-byte copy cadence.

## Interface
- No parameters: data width is 8 bits and address space is 256 bytes, both fixed.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  request transfer; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src  in  8  copy source base address (ignored in fill)
- dst  in  8  destination base address
- len  in  8  byte count, 0–255; 0 = no transfer
- fill_val  in  8  constant written in fill mode
- core_addr  in  8  core memory address
- core_we  in  1  core write enable
- core_di  in  8  core write data
- mem_dout  in  8  dmem read data (combinational from mem_addr)
- mem_addr  out  8  to dmem addr
- mem_we  out  1  to dmem we
- mem_di  out  8  to dmem di
- busy  out  1  high in READ/WRITE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, WRITE, DONE. Reset enters IDLE.
- IDLE/DONE: mem_addr/mem_we/mem_di = core_addr/core_we/core_di (pure mux, no register).
- READ/WRITE: the core port is ignored entirely. Core writes are dropped, not queued.
- IDLE, start=1, len=0 → DONE. No memory write occurs.
- IDLE, start=1, len≠0: latch mode, fill_val and count=len.
  - Direction check: d = (dst − src) mod 256. Backward if mode=0 and 1 ≤ d ≤ len−1; otherwise forward.
  - Forward: src_ptr=src, dst_ptr=dst.
  - Backward: src_ptr=src+len−1, dst_ptr=dst+len−1, both mod 256.
  - Next state: READ if copy, WRITE if fill.
- READ: mem_addr=src_ptr, mem_we=0. Capture mem_dout into data_reg. → WRITE.
- WRITE: mem_addr=dst_ptr, mem_we=1, mem_di = data_reg (copy) or fill_val (fill).
  - Pointers step ±1 mod 256; count decrements.
  - count==1 → DONE; else → READ (copy) or WRITE (fill).
- DONE: done=1, busy=0, start ignored. → IDLE unconditionally.
- All address arithmetic is 8-bit modulo 256. Regions wrapping past 0xFF continue at 0x00.
- Backward ordering guarantees an overlapping copy reproduces the original source bytes at the destination.
- src==dst copy proceeds normally (rewrites identical bytes).

## Timing
- Reset values: state IDLE, busy=0, done=0. mem_* follow the core inputs. Internal registers are 0.
- Asynchronous reset mid-transfer: mem_we drops to core_we immediately, without waiting for an edge. Bytes already written stay written. No done pulse.
- start sampled at edge E0. Copy of N bytes:
  - READ/WRITE alternate in cycles 1..2N.
  - Byte k (k from 1) is written at the end of cycle 2k.
  - done is high in cycle 2N+1; IDLE from cycle 2N+2.
- Fill of N bytes: WRITE in cycles 1..N, done in cycle N+1.
- len=0: done in cycle 1, busy never asserted.
- busy and done are never high together.
- A new start is accepted no earlier than the IDLE cycle after done.
- Outputs are combinational decodes of state and registers.

## Test plan
- Forward copy: preload dmem[0x10..0x13]=11,22,33,44; copy src=0x10 dst=0x40 len=4 → dmem[0x40..0x43]=11,22,33,44; busy high 8 cycles; done in cycle 9; source unchanged.
- Overlap backward: dmem[0x20..0x23]=1,2,3,4; copy src=0x20 dst=0x22 len=4 → dmem[0x22..0x25]=1,2,3,4; first write at 0x25, last at 0x22.
- Fill with wrap: fill dst=0xFE len=3 fill_val=0xA5 → dmem[0xFE],[0xFF],[0x00]=0xA5; dmem[0x01] untouched; done in cycle 4.
- Zero length and arbitration: start len=0 → done in cycle 1, mem_we never from engine. Then copy len=2 while core_we=1 to 0x80 → 0x80 unchanged. A second start during busy is ignored.
- Reset mid-copy: copy len=4, assert reset in cycle 5 → mem_we low at once, busy=0, done never pulses, only bytes 1–2 written. A subsequent copy completes correctly.
- Core pass-through: in IDLE, core writes 0x5A to 0x33 and reads back 0x5A via mem_dout with mem_addr=0x33.

Source files
------------

// File: rtl/dmem_dma.sv
// Block-copy / block-fill engine owning the single dmem address/write port.
// Passes core requests through when idle; 2 cycles per copied byte, 1 per filled byte.
module dmem_dma (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic [7:0] fill_val,
    input  logic [7:0] core_addr,
    input  logic       core_we,
    input  logic [7:0] core_di,
    input  logic [7:0] mem_dout,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_di,
    output logic       busy,
    output logic       done
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_mode;
    logic            w_mode_nxt;
    logic            r_back;
    logic            w_back_nxt;
    logic [DW-1:0]   r_fill_val;
    logic [DW-1:0]   w_fill_val_nxt;
    logic [AW-1:0]   r_count;
    logic [AW-1:0]   w_count_nxt;
    logic [AW-1:0]   r_src_ptr;
    logic [AW-1:0]   w_src_ptr_nxt;
    logic [AW-1:0]   r_dst_ptr;
    logic [AW-1:0]   w_dst_ptr_nxt;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   w_data_nxt;

    logic [AW-1:0]   w_diff;
    logic [AW-1:0]   w_len_m1;
    logic            w_back;
    logic [AW-1:0]   w_step;

    // Copy runs backward only when dst lands inside the source block (overlap hazard).
    assign w_diff   = AW'(dst - src);
    assign w_len_m1 = AW'(len - AW'(1));
    assign w_back   = !mode && (w_diff != '0) && (w_diff <= w_len_m1);
    assign w_step   = r_back ? '1 : AW'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_back_nxt     = r_back;
        w_fill_val_nxt = r_fill_val;
        w_count_nxt    = r_count;
        w_src_ptr_nxt  = r_src_ptr;
        w_dst_ptr_nxt  = r_dst_ptr;
        w_data_nxt     = r_data;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_mode_nxt     = mode;
                        w_back_nxt     = w_back;
                        w_fill_val_nxt = fill_val;
                        w_count_nxt    = len;
                        w_src_ptr_nxt  = w_back ? AW'(src + w_len_m1) : src;
                        w_dst_ptr_nxt  = w_back ? AW'(dst + w_len_m1) : dst;
                        w_state_nxt    = mode ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                w_data_nxt  = mem_dout;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_src_ptr_nxt = AW'(r_src_ptr + w_step);
                w_dst_ptr_nxt = AW'(r_dst_ptr + w_step);
                w_count_nxt   = AW'(r_count - AW'(1));
                if (r_count == AW'(1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = r_mode ? S_WRITE : S_READ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_back     <= 1'b0;
            r_fill_val <= '0;
            r_count    <= '0;
            r_src_ptr  <= '0;
            r_dst_ptr  <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_back     <= w_back_nxt;
            r_fill_val <= w_fill_val_nxt;
            r_count    <= w_count_nxt;
            r_src_ptr  <= w_src_ptr_nxt;
            r_dst_ptr  <= w_dst_ptr_nxt;
            r_data     <= w_data_nxt;
        end
    end

    // Port mux: core owns dmem outside READ/WRITE, so an async reset hands it back at once.
    always_comb begin
        mem_addr = core_addr;
        mem_we   = core_we;
        mem_di   = core_di;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_READ: begin
                mem_addr = r_src_ptr;
                mem_we   = 1'b0;
                mem_di   = r_data;
                busy     = 1'b1;
            end
            S_WRITE: begin
                mem_addr = r_dst_ptr;
                mem_we   = 1'b1;
                mem_di   = r_mode ? r_fill_val : r_data;
                busy     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
